// File: rtl/pg_input_if.sv
// Operand/result bundle for the generate/propagate input stage.
// The master drives operands and the slave returns per-bit generate/propagate.
interface pg_input_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_in;
    logic             out_valid;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic             c_in_q;

    modport master (
        output in_valid, x, y, c_in,
        input  out_valid, gen, prop, c_in_q
    );

    modport slave (
        input  in_valid, x, y, c_in,
        output out_valid, gen, prop, c_in_q
    );
endinterface

// File: rtl/pg_input.sv
// Bit-level generate/propagate stage feeding the parallel-prefix adder tree.
// The carry-in is folded into gen[0] so the tree needs no separate carry input.
module pg_input #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          REGISTERED = 1'b1
) (
    input logic       clk,
    input logic       rst,
    pg_input_if.slave bus
);
    logic [WIDTH-1:0] gen_c;
    logic [WIDTH-1:0] prop_c;

    always_comb begin
        gen_c     = bus.x & bus.y;
        prop_c    = bus.x ^ bus.y;
        // Bit 0 generates when the carry-in propagates through it (majority).
        gen_c[0]  = (bus.x[0] & bus.y[0]) | (bus.c_in & prop_c[0]);
    end

    if (REGISTERED) begin : g_reg
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] gen_q, gen_d;
        logic [WIDTH-1:0] prop_q, prop_d;
        logic             cin_q, cin_d;

        always_comb begin
            valid_d = bus.in_valid;
            gen_d   = gen_q;
            prop_d  = prop_q;
            cin_d   = cin_q;
            // Data only loads on a valid beat, so idle-cycle junk never reaches the outputs.
            if (bus.in_valid) begin
                gen_d  = gen_c;
                prop_d = prop_c;
                cin_d  = bus.c_in;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                gen_q   <= '0;
                prop_q  <= '0;
                cin_q   <= 1'b0;
            end else begin
                valid_q <= valid_d;
                gen_q   <= gen_d;
                prop_q  <= prop_d;
                cin_q   <= cin_d;
            end
        end

        assign bus.out_valid = valid_q;
        assign bus.gen       = gen_q;
        assign bus.prop      = prop_q;
        assign bus.c_in_q    = cin_q;
    end else begin : g_comb
        logic unused_clk;
        assign unused_clk = clk;

        assign bus.out_valid = bus.in_valid & ~rst;
        assign bus.gen       = gen_c;
        assign bus.prop      = prop_c;
        assign bus.c_in_q    = bus.c_in;
    end
endmodule

// File: tb/tb_pg_input.sv
// Scoreboard bench for pg_input: registered WIDTH=1 and WIDTH=8 instances
// plus a combinational WIDTH=4 instance.
module tb_pg_input;
    typedef struct packed {
        logic [63:0] g;
        logic [63:0] p;
        logic        c;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   vcnt8;
    exp_t q1[$];
    exp_t q8[$];

    pg_input_if #(.WIDTH(1)) b1 ();
    pg_input_if #(.WIDTH(8)) b8 ();
    pg_input_if #(.WIDTH(4)) b4 ();

    pg_input #(.WIDTH(1), .REGISTERED(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    pg_input #(.WIDTH(8), .REGISTERED(1'b1)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));
    pg_input #(.WIDTH(4), .REGISTERED(1'b0)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic c);
        exp_t e;
        e.g    = a & b;
        e.p    = a ^ b;
        e.g[0] = (a[0] & b[0]) | (c & (a[0] ^ b[0]));
        e.c    = c;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs are set away from the edge; tasks return 1 time unit after the sampling edge.
    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        b1.in_valid = v;
        b1.x        = a;
        b1.y        = b;
        b1.c_in     = c;
        if (v && !rst) q1.push_back(model({63'd0, a}, {63'd0, b}, c));
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        b8.in_valid = v;
        b8.x        = a;
        b8.y        = b;
        b8.c_in     = c;
        if (v && !rst) q8.push_back(model({56'd0, a}, {56'd0, b}, c));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (b1.out_valid === 1'b1) begin
            if (q1.size() == 0) check("sb1_spurious_valid", 64'(b1.out_valid), 64'd0);
            else begin
                e = q1.pop_front();
                check("gen1", 64'(b1.gen), e.g);
                check("prop1", 64'(b1.prop), e.p);
                check("cinq1", 64'(b1.c_in_q), 64'(e.c));
            end
        end
        if (b8.out_valid === 1'b1) begin
            vcnt8++;
            if (q8.size() == 0) check("sb8_spurious_valid", 64'(b8.out_valid), 64'd0);
            else begin
                e = q8.pop_front();
                check("gen8", 64'(b8.gen), e.g);
                check("prop8", 64'(b8.prop), e.p);
                check("cinq8", 64'(b8.c_in_q), 64'(e.c));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       last;
        logic [7:0] ra;
        logic [7:0] rb;
        int         base;
        logic [2:0] v3;

        n_checks = 0;
        n_fail   = 0;
        vcnt8    = 0;
        rst      = 1'b1;
        b1.in_valid = 1'b0; b1.x = '0; b1.y = '0; b1.c_in = 1'b0;
        b8.in_valid = 1'b0; b8.x = '0; b8.y = '0; b8.c_in = 1'b0;
        b4.in_valid = 1'b0; b4.x = '0; b4.y = '0; b4.c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid8", 64'(b8.out_valid), 64'd0);
        check("rst_gen8", 64'(b8.gen), 64'd0);
        check("rst_prop8", 64'(b8.prop), 64'd0);
        check("rst_cinq8", 64'(b8.c_in_q), 64'd0);
        check("rst_valid1", 64'(b1.out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Exhaustive WIDTH=1 truth table, back to back.
        for (int i = 0; i < 8; i++) begin
            v3 = 3'(i);
            drive1(1'b1, v3[2], v3[1], v3[0]);
        end
        drive1(1'b0, 1'b0, 1'b0, 1'b0);

        // Directed WIDTH=8 case: gen[0] only set because of the carry-in.
        drive8(1'b1, 8'hA5, 8'h3C, 1'b1);
        @(negedge clk);
        check("dir_valid", 64'(b8.out_valid), 64'd1);
        check("dir_gen", 64'(b8.gen), 64'h25);
        check("dir_prop", 64'(b8.prop), 64'h99);
        check("dir_cinq", 64'(b8.c_in_q), 64'd1);
        check("dir_gen0_from_cin", 64'(b8.gen[0]), 64'd1);

        // Reset wins over a simultaneous valid beat.
        rst = 1'b1;
        drive8(1'b1, 8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        check("rstv_valid", 64'(b8.out_valid), 64'd0);
        check("rstv_gen", 64'(b8.gen), 64'd0);
        check("rstv_prop", 64'(b8.prop), 64'd0);
        check("rstv_cinq", 64'(b8.c_in_q), 64'd0);
        rst = 1'b0;
        drive8(1'b1, 8'h01, 8'h00, 1'b0);
        @(negedge clk);
        check("post_rst_valid", 64'(b8.out_valid), 64'd1);
        check("post_rst_gen", 64'(b8.gen), 64'h00);
        check("post_rst_prop", 64'(b8.prop), 64'h01);

        // Hold: idle cycles with random (and once unknown) operands.
        ra = 8'($urandom);
        rb = 8'($urandom);
        last = model({56'd0, ra}, {56'd0, rb}, 1'b1);
        drive8(1'b1, ra, rb, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) drive8(1'b0, 8'hxx, 8'hxx, 1'bx);
            else drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(negedge clk);
            check("hold_valid", 64'(b8.out_valid), 64'd0);
            check("hold_gen", 64'(b8.gen), last.g);
            check("hold_prop", 64'(b8.prop), last.p);
            check("hold_cinq", 64'(b8.c_in_q), 64'(last.c));
        end

        // Streaming: 16 back-to-back beats.
        @(posedge clk);
        #1;
        base = vcnt8;
        for (int k = 0; k < 16; k++) drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        check("stream_count", 64'(vcnt8 - base), 64'd16);

        // Combinational WIDTH=4 instance, checked within the same low phase.
        b4.in_valid = 1'b1; b4.x = 4'hF; b4.y = 4'h1; b4.c_in = 1'b0;
        #1;
        check("comb_gen", 64'(b4.gen), 64'h1);
        check("comb_prop", 64'(b4.prop), 64'hE);
        check("comb_valid", 64'(b4.out_valid), 64'd1);
        check("comb_cinq", 64'(b4.c_in_q), 64'd0);
        b4.x = 4'hA; b4.y = 4'h6; b4.c_in = 1'b1;
        last = model(64'hA, 64'h6, 1'b1);
        #1;
        check("comb2_gen", 64'(b4.gen), last.g);
        check("comb2_prop", 64'(b4.prop), last.p);
        check("comb2_cinq", 64'(b4.c_in_q), 64'(last.c));
        b4.in_valid = 1'b0;
        #1;
        check("comb_idle_valid", 64'(b4.out_valid), 64'd0);
        b4.in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("comb_rst_valid", 64'(b4.out_valid), 64'd0);
        check("comb_rst_gen", 64'(b4.gen), last.g);
        rst = 1'b0;
        b4.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pg_input.md
Name: pg_input

Overview:
Bit-level generate/propagate input stage of the parallel-prefix adder. It takes two WIDTH-bit operands and a carry-in, and forms per-bit generate and propagate signals. The carry-in is folded into bit 0 so the prefix tree needs no separate carry input. Outputs are registered, with a valid flag, and feed the prefix (Kogge-Stone/Brent-Kung) network.

Parameters:
WIDTH, 8, operand width in bits (legal range 1 to 64).
REGISTERED, 1, 1 means outputs are registered with 1-cycle latency; 0 means outputs are combinational and valid passes straight through.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  x, y and c_in are valid this cycle
x  input  WIDTH  operand A
y  input  WIDTH  operand B
c_in  input  1  adder carry-in
out_valid  output  1  gen, prop and c_in_q are valid
gen  output  WIDTH  per-bit generate
prop  output  WIDTH  per-bit propagate
c_in_q  output  1  carry-in aligned with gen/prop, used by the sum stage

Behaviour:
- Bits i = 1 to WIDTH-1: gen[i] = x[i] & y[i]; prop[i] = x[i] ^ y[i].
- Bit 0 absorbs the carry-in:
  - gen[0] = majority(x[0], y[0], c_in) = x[0]&y[0] | c_in&(x[0]^y[0]).
  - prop[0] = x[0] ^ y[0]. Sum bit 0 is later formed as prop[0] ^ c_in_q.
- For WIDTH=1 only the bit-0 rules apply.
- REGISTERED=1:
  - All outputs update on the rising edge of clk.
  - Latency is 1 cycle: values sampled at edge n appear after edge n.
  - out_valid follows in_valid delayed by one cycle.
  - gen, prop and c_in_q load only when in_valid=1 and otherwise hold their last value.
- REGISTERED=0:
  - Outputs are pure combinational functions of the inputs.
  - out_valid = in_valid; c_in_q = c_in.
  - rst has no effect on the data outputs; out_valid is forced to 0 while rst=1.
- Reset (REGISTERED=1): while rst=1 at a clock edge, out_valid, gen, prop and c_in_q all go to 0. Reset takes priority over a simultaneous in_valid.
- Reset mid-stream: any in-flight transaction is discarded and no out_valid pulse is produced for it. The first in_valid after rst deasserts produces out_valid one cycle later.
- Back-to-back in_valid gives one result per cycle. There is no backpressure and no internal state beyond the output register.
- X/Z on inputs while in_valid=0 must not propagate to the outputs when REGISTERED=1.

Test Plan:
- Exhaustive truth table, WIDTH=1, all 8 (x,y,c_in) combinations with in_valid=1:
  - {0,0,0} -> gen=0, prop=0
  - {0,1,0} -> gen=0, prop=1
  - {1,0,0} -> gen=0, prop=1
  - {1,1,0} -> gen=1, prop=0
  - {0,0,1} -> gen=0, prop=0
  - {0,1,1} -> gen=1, prop=1
  - {1,0,1} -> gen=1, prop=1
  - {1,1,1} -> gen=1, prop=0
  - Each result appears one cycle after its input.
- WIDTH=8, x=8'hA5, y=8'h3C, c_in=1 -> gen=8'h25, prop=8'h99, c_in_q=1, out_valid=1 next cycle. Check that gen[0]=1 comes from the carry-in.
- Reset: assert rst with in_valid=1 and x=y=8'hFF -> next cycle all outputs are 0. Deassert rst, apply x=8'h01, y=8'h00, c_in=0 -> gen=8'h00, prop=8'h01 after one cycle.
- Hold: one valid transaction then in_valid=0 with random x/y for 5 cycles -> gen/prop stay at the last loaded values and out_valid=0.
- Streaming: 16 random in_valid=1 cycles back-to-back -> 16 consecutive out_valid cycles, each matching the reference formula with 1-cycle lag.
- REGISTERED=0, WIDTH=4: x=4'hF, y=4'h1, c_in=0 -> gen=4'h1, prop=4'hE in the same cycle, and out_valid equals in_valid.
